// File: rtl/hs_bus_amba_axis_pkg.sv
// Shared constants and helpers for the AXI-Stream FIFO slice.
package hs_bus_amba_axis_pkg;

  localparam int unsigned MIN_DEPTH = 2;
  localparam int unsigned MAX_DEPTH = 4096;

  // Width of one stored beat: tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
  function automatic int unsigned entry_width(
    input int unsigned data_w,
    input int unsigned strb_w,
    input int unsigned keep_w,
    input int unsigned id_w,
    input int unsigned dest_w,
    input int unsigned user_w
  );
    return data_w + strb_w + keep_w + 1 + id_w + dest_w + user_w;
  endfunction

  // Depth must be a power of two within the supported range.
  function automatic bit is_legal_depth(input int unsigned depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH) &&
           ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/hs_bus_amba_axis_if.sv
// AXI-Stream bundle with master/slave views.
interface hs_bus_amba_axis_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TSTRB_WIDTH-1:0] tstrb;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  logic                   twakeup;

  modport master (
    output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
    output tready
  );
endinterface

// File: rtl/hs_bus_amba_axis_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, asynchronous read.
// Contents are intentionally not reset.
module hs_bus_amba_axis_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/hs_bus_amba_axis_fifo.sv
// First-word fall-through AXI-Stream FIFO with registered handshake/flags.
module hs_bus_amba_axis_fifo
  import hs_bus_amba_axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int DEPTH       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  hs_bus_amba_axis_if.slave        s_axis_if,
  hs_bus_amba_axis_if.master       m_axis_if,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = entry_width(TDATA_WIDTH, TSTRB_WIDTH, TKEEP_WIDTH,
                                           TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);

  if (!is_legal_depth(DEPTH)) begin : g_bad_depth
    $error("hs_bus_amba_axis_fifo: DEPTH must be a power of two in 2..4096");
  end

  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [AW:0]   fill_q, fill_n;
  logic          full_q, full_n, empty_q, empty_n, ready_q;
  logic          push, pop;
  logic [EW-1:0] wr_entry, rd_entry;

  assign wr_entry = {s_axis_if.tdata, s_axis_if.tstrb, s_axis_if.tkeep,
                     s_axis_if.tlast, s_axis_if.tid, s_axis_if.tdest,
                     s_axis_if.tuser};

  assign {m_axis_if.tdata, m_axis_if.tstrb, m_axis_if.tkeep, m_axis_if.tlast,
          m_axis_if.tid, m_axis_if.tdest, m_axis_if.tuser} = rd_entry;

  assign s_axis_if.tready = ready_q;
  assign m_axis_if.tvalid = !empty_q;
  assign m_axis_if.twakeup = !empty_q || s_axis_if.twakeup;
  assign fill_level = fill_q;
  assign full  = full_q;
  assign empty = empty_q;

  hs_bus_amba_axis_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  // Handshake qualification and next pointer/flag values.
  always_comb begin
    push     = s_axis_if.tvalid && ready_q;
    pop      = !empty_q && m_axis_if.tready;
    wr_ptr_n = wr_ptr + {{AW{1'b0}}, push};
    rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
    fill_n   = wr_ptr_n - rd_ptr_n;
    full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
               (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    empty_n  = (wr_ptr_n == rd_ptr_n);
  end

  // Pointer, flag and ready registers; ready follows the next full flag so
  // a pop from full only reopens the input one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      fill_q  <= fill_n;
      full_q  <= full_n;
      empty_q <= empty_n;
      ready_q <= !full_n;
    end
  end
endmodule

// File: doc/hs_bus_amba_axis_fifo.md
HS_BUS_AMBA_AXIS_FIFO -- requirements
Module: hs_bus_amba_axis_fifo

Interface
REQ-001 SHALL have parameter TDATA_WIDTH, default 8, tdata width in bits.
REQ-002 SHALL have parameter TID_WIDTH, default 1, tid width.
REQ-003 SHALL have parameter TDEST_WIDTH, default 1, tdest width.
REQ-004 SHALL have parameter TUSER_WIDTH, default 1, tuser width.
REQ-005 SHALL have parameter TSTRB_WIDTH, default TDATA_WIDTH/8, tstrb width.
REQ-006 SHALL have parameter TKEEP_WIDTH, default TDATA_WIDTH/8, tkeep width.
REQ-007 SHALL have parameter DEPTH, default 16, entry count; power of two, 2..4096; any other value is an elaboration error.
REQ-008 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-010 SHALL have port s_axis_if, hs_bus_amba_axis_if.slave, all fields; upstream AXI-Stream input.
REQ-011 SHALL have port m_axis_if, hs_bus_amba_axis_if.master, all fields; downstream AXI-Stream output.
REQ-012 SHALL have port fill_level, output, $clog2(DEPTH)+1, current stored beat count.
REQ-013 SHALL have port full, output, 1, fill_level==DEPTH.
REQ-014 SHALL have port empty, output, 1, fill_level==0.

Function
REQ-015 Each beat SHALL store tdata, tstrb, tkeep, tlast, tid, tdest and tuser as one entry and emit them unmodified, in order.
REQ-016 Push SHALL occur when s_axis_if.tvalid && s_axis_if.tready.
REQ-017 Pop SHALL occur when m_axis_if.tvalid && m_axis_if.tready.
REQ-018 s_axis_if.tready SHALL equal !full and SHALL be driven from registers only, with no combinational path from m_axis_if.tready.
REQ-019 m_axis_if.tvalid SHALL equal !empty, and the payload fields SHALL show the oldest entry (first-word fall-through).
REQ-020 Latency SHALL be 1 cycle: a beat pushed at edge N is valid on m_axis_if after edge N.
REQ-021 Payload SHALL stay stable while m_axis_if.tvalid && !m_axis_if.tready.
REQ-022 Push and pop in the same cycle SHALL leave fill_level unchanged and advance both pointers.
REQ-023 When full, a pop SHALL NOT permit a push in the same cycle; tready rises the cycle after the pop.
REQ-024 When empty, an incoming beat SHALL NOT pass through in the same cycle, so there is no combinational bypass.
REQ-025 Read and write pointers SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full and empty SHALL be derived from the MSB and index comparison.
REQ-026 fill_level, full and empty SHALL be registered and consistent with the pointers every cycle.
REQ-027 m_axis_if.twakeup SHALL be 1 whenever !empty or s_axis_if.twakeup is high.
REQ-028 s_axis_if.tvalid deassertion without tready SHALL be tolerated, with no stored state change.

Reset
REQ-029 While rst is high at a clk edge, the pointers and fill_level SHALL be 0, empty=1, full=0, s_axis_if.tready=0, and m_axis_if.tvalid=0.
REQ-030 s_axis_if.tready SHALL rise on the first edge after rst is low.
REQ-031 Reset mid-operation SHALL discard all stored beats, including partial packets, with no emission afterward.
REQ-032 Storage array contents SHALL NOT be reset; payload outputs are don't-care while tvalid=0.

Structure
REQ-033 Package hs_bus_amba_axis_pkg SHALL hold the entry typedef builder constants and the DEPTH legality check function.
REQ-034 Storage SHALL be one sub-module hs_bus_amba_axis_fifo_mem: simple dual-port, one write port, asynchronous read port, no reset.
REQ-035 Pointer, flag and handshake logic SHALL stay in hs_bus_amba_axis_fifo.

Verification (DEPTH=4, TDATA_WIDTH=8)
REQ-036 Reset: hold rst for 3 cycles, then release -> tready=0 during reset, tready=1 on the first cycle after, tvalid=0, fill_level=0.
REQ-037 Fill: push 0x11,0x22,0x33,0x44 with m tready=0 -> full=1, tready=0, fill_level=4; a 5th beat 0x55 is held and not stored.
REQ-038 Full plus pop: from full, pop one beat while tvalid offers 0x55 -> 0x11 is output, no push that cycle, tready=1 next cycle, then 0x55 is stored.
REQ-039 Streaming: continuous valid/ready with 20 beats 0x00..0x13, tlast on 0x07 and 0x13 -> identical order, tlast and sideband preserved, fill_level stays at 1 in steady state.
REQ-040 Random backpressure: 1000 beats with random tvalid and tready -> output matches the scoreboard, pointers wrap at least 100 times, and stall stability holds.
REQ-041 Mid-reset: with 3 beats stored, assert rst for 1 cycle -> fill_level=0 and none of the 3 beats is ever emitted.
